f_caller: RTL and testbench
===========================

# f_caller

Initiator for the start/done call protocol used by the generated function blocks (callee ports `start`, `a`, `b`, `result`, `done`). It accepts argument pairs from an upstream valid/ready stream and issues exactly one callee call per pair. It waits for the callee's `done`, then presents `result` downstream on a valid/ready stream. It sits between a producer and one generated callee, and adds a call counter and a sticky timeout watchdog.

## Interface
- `W`, 32, data width of arguments and result
- `TIMEOUT`, 64, maximum wait cycles per call before error (≥ 4)

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low; all state clears while low
- `in_valid` in 1: upstream argument pair valid
- `in_ready` out 1: caller can accept a pair
- `in_a`, `in_b` in W: arguments
- `out_valid` out 1: result available
- `out_ready` in 1: downstream accepts result
- `out_result` out W: returned result
- `call_start` out 1: start pulse to callee
- `call_a`, `call_b` out W: arguments to callee
- `call_result` in W: callee result
- `call_done` in 1: callee done (level, sticky between calls)
- `busy` out 1: high in every state except IDLE
- `timeout_err` out 1: sticky watchdog error
- `call_count` out 16: completed calls, wraps

## Operation
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, OUTPUT, ERROR. Reset state is IDLE.
- IDLE
  - `in_ready` = 1, gated to 0 while `reset` is low.
  - On `in_valid & in_ready`: register `in_a`/`in_b` into `call_a`/`call_b`, then go to ISSUE.
- ISSUE
  - `call_start` = 1 for exactly this one cycle.
  - Clear the wait timer, then go to WAIT_LOW.
- WAIT_LOW
  - `call_done` may still be high from the previous call and is ignored as completion.
  - On sampling `call_done` = 0, go to WAIT_HIGH.
- WAIT_HIGH
  - On sampling `call_done` = 1: register `call_result` into `out_result` and increment `call_count`.
  - Then go to OUTPUT.
- OUTPUT
  - `out_valid` = 1; `out_result` is held.
  - On `out_ready`, go to IDLE.
- Watchdog
  - The timer increments on every cycle spent in WAIT_LOW or WAIT_HIGH.
  - If TIMEOUT wait cycles elapse without reaching OUTPUT, go to ERROR.
- ERROR
  - `timeout_err` = 1.
  - `in_ready`, `out_valid`, `call_start` = 0; `busy` = 1.
  - Stays in ERROR until reset.
- `call_a`/`call_b` stay stable from acceptance until the next acceptance. The callee samples them one cycle after it sees start.
- `call_start` is never asserted for two consecutive cycles. A held start would retrigger the callee when it returns to idle.
- `out_result` keeps the last result after the handshake. Reset value is 0.
- `call_count` wraps 0xFFFF → 0x0000.
- Reset values: `in_ready` 0 (while low), `out_valid` 0, `out_result` 0, `call_start` 0, `call_a`/`call_b` 0, `busy` 0, `timeout_err` 0, `call_count` 0.
- Reset mid-call returns the caller to IDLE immediately and drops `call_start`. Any in-flight result is discarded.
- The watchdog timer has ≥ 8 bits of width.

## Timing
- Edges below are numbered from E0, the edge at which `in_valid & in_ready` is sampled.
- `call_start` is high between E0 and E1.
- Against a standard generated callee:
  - `call_done` reads 0 at E3 and 1 at E4.
  - `out_valid` rises after E4: latency 4 cycles from acceptance.
- With `out_ready` already high: OUTPUT at E4, IDLE after E5, next acceptance at E6. Throughput is 1 pair per 6 cycles.
- `out_valid` held low by `out_ready` = 0 extends OUTPUT. No data changes and no new call is issued.
- The timeout fires at the edge ending wait cycle TIMEOUT, counted from the first WAIT_LOW cycle.

## Test plan
- Reset then release, no input → all outputs 0, `in_ready` 1 after release, `call_start` never pulses.
- Pair a=3, b=4 into a real generated (a+b)² callee → `call_start` pulses 1 cycle, `out_valid` after E4, `out_result` = 49, `call_count` = 1.
- a=0xFFFFFFFF, b=1 → `out_result` = 0 (mod 2^32). Then a=5, b=0 back to back with `out_ready` = 1 → second result 25, acceptances 6 cycles apart.
- Hold `out_ready` = 0 for 5 cycles after the result 49 → `out_valid` and `out_result` stable, `in_ready` 0, no `call_start`. Then `out_ready` = 1 → IDLE.
- Stub callee keeps `call_done` = 1 forever (TIMEOUT = 8) → `timeout_err` rises 8 wait cycles after WAIT_LOW entry. `in_ready` stays 0 until reset, and reset clears `timeout_err`.
- Assert `reset` low during WAIT_HIGH → immediate return to IDLE with all outputs at reset values. After release, the new call a=1, b=1 returns 4.

Source files
------------

// File: rtl/f_caller.sv
// f_caller: issues one start/done call to a generated callee per accepted
// argument pair and returns the callee result on a valid/ready stream.
// Includes a completed-call counter and a sticky timeout watchdog.
module f_caller #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         call_start,
  output logic [W-1:0] call_a,
  output logic [W-1:0] call_b,
  input  logic [W-1:0] call_result,
  input  logic         call_done,
  output logic         busy,
  output logic         timeout_err,
  output logic [15:0]  call_count
);

  // Timer is at least 8 bits and wide enough to hold TIMEOUT.
  localparam int unsigned TimerW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitLow,
    StWaitHigh,
    StOutput,
    StError
  } state_e;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                call_start_q;
  logic                busy_q;
  logic                timeout_err_q;
  logic [W-1:0]        call_a_q;
  logic [W-1:0]        call_b_q;
  logic [W-1:0]        out_result_q;
  logic [15:0]         call_count_q;

  // Call sequencing FSM with registered outputs and wait watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      call_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      call_a_q      <= '0;
      call_b_q      <= '0;
      out_result_q  <= '0;
      call_count_q  <= '0;
    end else begin
      // Start is a single-cycle pulse; only acceptance raises it.
      call_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            call_a_q     <= in_a;
            call_b_q     <= in_b;
            call_start_q <= 1'b1;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWaitLow;
        end
        StWaitLow: begin
          // A done left high by the previous call is not a completion.
          timer_q <= timer_q + TimerW'(1);
          if (timer_q == TimerLast) begin
            timeout_err_q <= 1'b1;
            state_q       <= StError;
          end else if (!call_done) begin
            state_q <= StWaitHigh;
          end
        end
        StWaitHigh: begin
          timer_q <= timer_q + TimerW'(1);
          // Completion on the final wait cycle still counts as in time.
          if (call_done) begin
            out_result_q <= call_result;
            call_count_q <= call_count_q + 16'd1;
            out_valid_q  <= 1'b1;
            state_q      <= StOutput;
          end else if (timer_q == TimerLast) begin
            timeout_err_q <= 1'b1;
            state_q       <= StError;
          end
        end
        StOutput: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StError: begin
          state_q <= StError;
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // in_ready must read 0 for the whole time reset is held low.
  assign in_ready    = in_ready_q & reset;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign call_start  = call_start_q;
  assign call_a      = call_a_q;
  assign call_b      = call_b_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign call_count  = call_count_q;

endmodule

// File: tb/tb_f_caller.sv
// Testbench for f_caller: behavioural (a+b)^2 callee, scoreboard of
// expected results, table-driven back-to-back vectors and hand sequences.
module tb_f_caller;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         call_start;
  logic [W-1:0] call_a;
  logic [W-1:0] call_b;
  logic [W-1:0] call_result;
  logic         call_done;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  call_count;

  f_caller #(.W(W), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .call_start  (call_start),
    .call_a      (call_a),
    .call_b      (call_b),
    .call_result (call_result),
    .call_done   (call_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .call_count  (call_count)
  );

  always #5 clk = ~clk;

  // Generated-style callee computing (a+b)^2; done is a sticky level.
  typedef enum logic [1:0] {CIdle, CLoad, CCalc} cstate_e;
  cstate_e      c_state;
  logic [W-1:0] c_a;
  logic [W-1:0] c_b;
  logic [W-1:0] c_res;
  logic         c_done;
  logic         stub;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_state <= CIdle;
      c_a     <= '0;
      c_b     <= '0;
      c_res   <= '0;
      c_done  <= 1'b0;
    end else begin
      case (c_state)
        CIdle: if (call_start) begin
          c_done  <= 1'b0;
          c_state <= CLoad;
        end
        CLoad: begin
          c_a     <= call_a;
          c_b     <= call_b;
          c_state <= CCalc;
        end
        CCalc: begin
          c_res   <= (c_a + c_b) * (c_a + c_b);
          c_done  <= 1'b1;
          c_state <= CIdle;
        end
        default: c_state <= CIdle;
      endcase
    end
  end

  assign call_result = c_res;
  assign call_done   = stub ? 1'b1 : c_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accepts = 0;
  int start_pulses = 0;
  int accept_cyc = 0;
  bit prev_start = 1'b0;
  logic [W-1:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: single-cycle start pulses and scoreboard pops on output handshake.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      prev_start = 1'b0;
    end else begin
      if (call_start) begin
        start_pulses++;
        check("start_single", W'(prev_start), 0);
      end
      prev_start = call_start;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", W'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e);
        end
      end
    end
  end

  // Present a pair until accepted; optionally queue its expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp, input bit expect_out);
    int n;
    n = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", W'(in_ready), 1);
    if (in_ready) begin
      if (expect_out) sb.push_back(exp);
      accept_cyc = cyc + 1;
      accepts++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", W'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int prev_acc;
    vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'd1,      exp: 32'd0};
    vecs[1] = '{a: 32'd5,         b: 32'd0,      exp: 32'd25};
    vecs[2] = '{a: 32'd10,        b: 32'd20,     exp: 32'd900};
    vecs[3] = '{a: 32'h1234,      b: 32'h4321,   exp: 32'h1C71_8E39};

    reset = 1'b0; stub = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // Reset state while held low, then idle after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_busy", W'(busy), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in_ready", W'(in_ready), 1);
    check("idle_busy", W'(busy), 0);
    check("idle_out_result", out_result, 0);
    check("idle_call_count", W'(call_count), 0);
    check("idle_timeout", W'(timeout_err), 0);
    check("idle_no_start", W'(start_pulses), 0);

    // First call: start pulse shape and 4-cycle latency.
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'd3, 32'd4, 32'd49, 1'b1);
    @(negedge clk);
    check("start_high", W'(call_start), 1);
    check("busy_high", W'(busy), 1);
    @(negedge clk);
    check("start_low", W'(call_start), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", W'(cyc - accept_cyc), 4);
    wait_drain();
    check("count_1", W'(call_count), 1);
    check("call_a_hold", call_a, 3);
    check("call_b_hold", call_b, 4);

    // Back-to-back table vectors: results and 6-cycle acceptance spacing.
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      if (i > 0) check("spacing", W'(accept_cyc - prev_acc), 6);
      prev_acc = accept_cyc;
    end
    wait_drain();
    check("count_5", W'(call_count), 5);

    // Backpressure: result held, no new call while out_ready is low.
    out_ready = 1'b0;
    send(32'd3, 32'd4, 32'd49, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 begin in_valid = 1'b1; in_a = 32'd7; in_b = 32'd8; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", W'(out_valid), 1);
      check("bp_result", out_result, 49);
      check("bp_in_ready", W'(in_ready), 0);
      check("bp_no_start", W'(call_start), 0);
    end
    @(posedge clk);
    #1 begin in_valid = 1'b0; out_ready = 1'b1; end
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_ready", W'(in_ready), 1);
    check("bp_idle_valid", W'(out_valid), 0);
    check("bp_result_kept", out_result, 49);
    check("count_6", W'(call_count), 6);
    @(posedge clk);
    #1;

    // Watchdog: done stuck high, error 8 wait cycles after WAIT_LOW entry.
    stub = 1'b1;
    send(32'd9, 32'd9, 32'd0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!timeout_err && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("timeout_lat", W'(cyc - accept_cyc), 9);
    @(posedge clk);
    #1 in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("err_in_ready", W'(in_ready), 0);
      check("err_busy", W'(busy), 1);
      check("err_no_start", W'(call_start), 0);
      check("err_sticky", W'(timeout_err), 1);
    end
    check("err_count", W'(call_count), 6);
    @(posedge clk);
    #1 begin in_valid = 1'b0; reset = 1'b0; end
    #1 check("err_cleared", W'(timeout_err), 0);
    @(posedge clk);
    #1 begin reset = 1'b1; stub = 1'b0; end

    // Reset during WAIT_HIGH discards the call; next call works.
    send(32'd1, 32'd1, 32'd4, 1'b1);
    wait_drain();
    send(32'd2, 32'd3, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_in_ready", W'(in_ready), 0);
    check("mid_out_valid", W'(out_valid), 0);
    check("mid_out_result", out_result, 0);
    check("mid_start", W'(call_start), 0);
    check("mid_call_a", call_a, 0);
    check("mid_call_b", call_b, 0);
    check("mid_busy", W'(busy), 0);
    check("mid_count", W'(call_count), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    send(32'd1, 32'd1, 32'd4, 1'b1);
    wait_drain();
    check("post_count", W'(call_count), 1);
    check("start_count", W'(start_pulses), W'(accepts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
